bus_drive_sequencer: RTL and testbench

//  Inverse of the 32:5 bus-select encoder: queues 5-bit bus-source codes from the

---
 rtl/bus_drive_sequencer.sv | 141 ++++++++++++++
 tb/tb_bus_drive_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bus_drive_sequencer.sv
// Bus drive sequencer: queues 5-bit bus-source codes and expands each one into a
// registered one-hot drive enable, with a dead gap between successive drivers.
module bus_drive_sequencer #(
  parameter int DEPTH        = 4,
  parameter int DRIVE_CYCLES = 1,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     src_valid,
  input  logic [4:0]               src_code,
  output logic                     src_ready,
  output logic [31:0]              drive_en,
  output logic [4:0]               drive_code,
  output logic                     drive_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CMAX  = (DRIVE_CYCLES > GAP_CYCLES) ? DRIVE_CYCLES : GAP_CYCLES;
  localparam int TMR_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [TMR_W-1:0] DRIVE_LOAD = TMR_W'(DRIVE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? TMR_W'(GAP_CYCLES - 1) : '0;
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [31:0]        drive_en_q, drive_en_d;
  logic [4:0]         drive_code_q, drive_code_d;
  logic               drive_valid_q, drive_valid_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]         mem_q [DEPTH];

  logic               push;
  logic               pop;
  logic               load;
  logic [4:0]         head_code;

  assign head_code = mem_q[rd_ptr_q];

  always_comb begin
    push          = src_valid && !clr && (count_q != FULL_COUNT);
    state_d       = state_q;
    tmr_d         = tmr_q;
    drive_en_d    = drive_en_q;
    drive_code_d  = drive_code_q;
    drive_valid_d = drive_valid_q;
    load          = 1'b0;

    case (state_q)
      ST_IDLE: load = 1'b1;
      ST_DRIVE: begin
        if (tmr_q == '0) begin
          drive_en_d    = '0;
          drive_code_d  = '0;
          drive_valid_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            tmr_d   = GAP_LOAD;
          end else begin
            load = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_q == '0) begin
          load = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loading from an empty FIFO just parks the FSM; the outputs are already zero.
    pop = load && (count_q != '0);
    if (load) begin
      if (pop) begin
        state_d       = ST_DRIVE;
        tmr_d         = DRIVE_LOAD;
        drive_en_d    = 32'd1 << head_code;
        drive_code_d  = head_code;
        drive_valid_d = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      drive_en_q    <= '0;
      drive_code_q  <= '0;
      drive_valid_q <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      drive_en_q    <= drive_en_d;
      drive_code_q  <= drive_code_d;
      drive_valid_q <= drive_valid_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= src_code;
    end
  end

  assign src_ready   = (count_q != FULL_COUNT);
  assign drive_en    = drive_en_q;
  assign drive_code  = drive_code_q;
  assign drive_valid = drive_valid_q;
  assign busy        = (state_q != ST_IDLE) || (count_q != '0);
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_bus_drive_sequencer.sv
// Directed and randomised checks of bus_drive_sequencer: instance a uses the default
// timing, instance b holds each source two cycles with no gap.
module tb_bus_drive_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_a, valid_a, ready_a, dvalid_a, busy_a;
  logic [4:0]  code_a, dcode_a;
  logic [31:0] en_a;
  logic [2:0]  cnt_a;

  logic        clr_b, valid_b, ready_b, dvalid_b, busy_b;
  logic [4:0]  code_b, dcode_b;
  logic [31:0] en_b;
  logic [2:0]  cnt_b;

  int vectors = 0;
  int miscompares = 0;

  bus_drive_sequencer #(.DEPTH(4), .DRIVE_CYCLES(1), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .clr(clr_a), .src_valid(valid_a), .src_code(code_a),
    .src_ready(ready_a), .drive_en(en_a), .drive_code(dcode_a),
    .drive_valid(dvalid_a), .busy(busy_a), .fifo_count(cnt_a)
  );

  bus_drive_sequencer #(.DEPTH(4), .DRIVE_CYCLES(2), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .clr(clr_b), .src_valid(valid_b), .src_code(code_b),
    .src_ready(ready_b), .drive_en(en_b), .drive_code(dcode_b),
    .drive_valid(dvalid_b), .busy(busy_b), .fifo_count(cnt_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clr_a = 1'b1; valid_a = 1'b1; code_a = 5'd9;
    clr_b = 1'b1; valid_b = 1'b1; code_b = 5'd9;
    for (int c = 0; c < 2; c++) begin
      tick;
      vectors++; if (en_a !== 32'h0) begin miscompares++; $display("FAIL reset_en_a: got %h want 0", en_a); end
      vectors++; if (dcode_a !== 5'd0 || dvalid_a !== 1'b0) begin miscompares++; $display("FAIL reset_code_a: got code %0d valid %b want 0 0", dcode_a, dvalid_a); end
      vectors++; if (busy_a !== 1'b0 || cnt_a !== 3'd0 || ready_a !== 1'b1) begin miscompares++; $display("FAIL reset_status_a: got busy %b cnt %0d ready %b want 0 0 1", busy_a, cnt_a, ready_a); end
      vectors++; if (en_b !== 32'h0 || cnt_b !== 3'd0 || busy_b !== 1'b0 || ready_b !== 1'b1) begin miscompares++; $display("FAIL reset_b: got en %h cnt %0d busy %b ready %b want 0 0 0 1", en_b, cnt_b, busy_b, ready_b); end
    end
    clr_a = 1'b0; valid_a = 1'b0; clr_b = 1'b0; valid_b = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      vectors++; if (en_a !== 32'h0 || en_b !== 32'h0 || cnt_a !== 3'd0 || cnt_b !== 3'd0) begin miscompares++; $display("FAIL reset_after: got en_a %h en_b %h cnt_a %0d cnt_b %0d want all 0", en_a, en_b, cnt_a, cnt_b); end
    end
  endtask

  task automatic test_single;
    valid_a = 1'b1; code_a = 5'd21;
    tick;
    valid_a = 1'b0;
    vectors++; if (en_a !== 32'h0 || cnt_a !== 3'd1 || busy_a !== 1'b1) begin miscompares++; $display("FAIL single_e0: got en %h cnt %0d busy %b want 0 1 1", en_a, cnt_a, busy_a); end
    tick;
    vectors++; if (en_a !== 32'h0020_0000 || dcode_a !== 5'd21 || dvalid_a !== 1'b1) begin miscompares++; $display("FAIL single_e1: got en %h code %0d valid %b want 00200000 21 1", en_a, dcode_a, dvalid_a); end
    vectors++; if (cnt_a !== 3'd0) begin miscompares++; $display("FAIL single_e1_cnt: got %0d want 0", cnt_a); end
    tick;
    vectors++; if (en_a !== 32'h0 || dcode_a !== 5'd0 || busy_a !== 1'b1) begin miscompares++; $display("FAIL single_e2: got en %h code %0d busy %b want 0 0 1", en_a, dcode_a, busy_a); end
    tick;
    vectors++; if (en_a !== 32'h0 || busy_a !== 1'b0) begin miscompares++; $display("FAIL single_e3: got en %h busy %b want 0 0", en_a, busy_a); end
  endtask

  task automatic test_burst;
    logic [4:0]  codes [5] = '{5'd0, 5'd31, 5'd7, 5'd7, 5'd9};
    logic [31:0] exp [10]  = '{32'h1, 32'h0, 32'h8000_0000, 32'h0, 32'h80,
                               32'h0, 32'h80, 32'h0, 32'h200, 32'h0};
    int idx = 0;
    logic rdy;
    for (int c = 0; c < 11; c++) begin
      valid_a = (idx < 5);
      code_a  = (idx < 5) ? codes[idx] : 5'd0;
      rdy     = ready_a;
      tick;
      if (valid_a && rdy) idx++;
      if (c >= 1) begin
        vectors++; if (en_a !== exp[c-1]) begin miscompares++; $display("FAIL burst_seq[%0d]: got %h want %h", c-1, en_a, exp[c-1]); end
      end
    end
    valid_a = 1'b0;
    vectors++; if (idx != 5) begin miscompares++; $display("FAIL burst_accepted: got %0d want 5", idx); end
  endtask

  task automatic test_full;
    logic [4:0] seen [$];
    for (int c = 0; c < 30; c++) begin
      valid_a = (c < 8);
      code_a  = (c < 8) ? 5'(c + 1) : 5'd0;
      tick;
      if (dvalid_a) seen.push_back(dcode_a);
      if (c == 6) begin
        vectors++; if (ready_a !== 1'b0 || cnt_a !== 3'd4) begin miscompares++; $display("FAIL full_reach: got ready %b cnt %0d want 0 4", ready_a, cnt_a); end
      end
      if (c == 7) begin
        vectors++; if (cnt_a !== 3'd3 || ready_a !== 1'b1) begin miscompares++; $display("FAIL full_drop: got cnt %0d ready %b want 3 1", cnt_a, ready_a); end
      end
    end
    valid_a = 1'b0;
    vectors++; if (seen.size() != 7) begin miscompares++; $display("FAIL full_drives: got %0d drives want 7", seen.size()); end
    for (int i = 0; i < seen.size() && i < 7; i++) begin
      vectors++; if (seen[i] !== 5'(i + 1)) begin miscompares++; $display("FAIL full_order[%0d]: got %0d want %0d", i, seen[i], i + 1); end
    end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL full_idle: got busy %b want 0", busy_a); end
  endtask

  task automatic test_gap0;
    logic [31:0] exp [5] = '{32'h8, 32'h8, 32'h10, 32'h10, 32'h0};
    valid_b = 1'b1; code_b = 5'd3;
    tick;
    code_b = 5'd4;
    for (int c = 0; c < 5; c++) begin
      tick;
      valid_b = 1'b0;
      vectors++; if (en_b !== exp[c] || !$onehot0(en_b)) begin miscompares++; $display("FAIL gap0_seq[%0d]: got %h want %h", c, en_b, exp[c]); end
    end
  endtask

  task automatic test_abort;
    valid_b = 1'b1; code_b = 5'd12;
    tick;
    code_b = 5'd1;
    tick;
    code_b = 5'd2;
    vectors++; if (en_b !== 32'h0000_1000) begin miscompares++; $display("FAIL abort_drive1: got %h want 00001000", en_b); end
    tick;
    valid_b = 1'b0;
    vectors++; if (en_b !== 32'h0000_1000 || cnt_b !== 3'd2) begin miscompares++; $display("FAIL abort_drive2: got en %h cnt %0d want 00001000 2", en_b, cnt_b); end
    clr_b = 1'b1;
    tick;
    clr_b = 1'b0;
    vectors++; if (en_b !== 32'h0 || dvalid_b !== 1'b0 || cnt_b !== 3'd0 || busy_b !== 1'b0) begin miscompares++; $display("FAIL abort_clr: got en %h valid %b cnt %0d busy %b want 0 0 0 0", en_b, dvalid_b, cnt_b, busy_b); end
    for (int c = 0; c < 6; c++) begin
      tick;
      vectors++; if (en_b !== 32'h0) begin miscompares++; $display("FAIL abort_after[%0d]: got %h want 0", c, en_b); end
    end
  endtask

  task automatic test_random;
    logic [4:0] q [$];
    logic [4:0] exp_code;
    logic       prev_v = 1'b0;
    logic       rdy;
    for (int c = 0; c < 4000; c++) begin
      if (c < 3980) begin
        clr_a   = ($urandom_range(0, 149) == 0);
        valid_a = 1'($urandom_range(0, 1));
        code_a  = 5'($urandom_range(0, 31));
      end else begin
        clr_a = 1'b0; valid_a = 1'b0; code_a = 5'd0;
      end
      rdy = ready_a;
      vectors++; if (rdy !== (q.size() != 4)) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, rdy, q.size() != 4); end
      tick;
      if (clr_a) begin
        q.delete();
        prev_v = 1'b0;
        vectors++; if (en_a !== 32'h0 || cnt_a !== 3'd0 || busy_a !== 1'b0) begin miscompares++; $display("FAIL rnd_clr[%0d]: got en %h cnt %0d busy %b want 0 0 0", c, en_a, cnt_a, busy_a); end
      end else begin
        if (dvalid_a) begin
          vectors++;
          if (prev_v) begin
            miscompares++; $display("FAIL rnd_gap[%0d]: got back-to-back drive want gap", c);
          end else if (q.size() == 0) begin
            miscompares++; $display("FAIL rnd_underflow[%0d]: got drive of %0d want none", c, dcode_a);
          end else begin
            exp_code = q.pop_front();
            if (dcode_a !== exp_code) begin miscompares++; $display("FAIL rnd_order[%0d]: got %0d want %0d", c, dcode_a, exp_code); end
          end
        end
        if (valid_a && rdy) q.push_back(code_a);
        vectors++; if (!$onehot0(en_a) || en_a !== (dvalid_a ? (32'd1 << dcode_a) : 32'h0) || (!dvalid_a && dcode_a !== 5'd0)) begin miscompares++; $display("FAIL rnd_decode[%0d]: got en %h code %0d valid %b", c, en_a, dcode_a, dvalid_a); end
        vectors++; if (cnt_a !== 3'(q.size())) begin miscompares++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, cnt_a, q.size()); end
        vectors++; if (busy_a !== (dvalid_a || prev_v || q.size() != 0)) begin miscompares++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, busy_a, dvalid_a || prev_v || q.size() != 0); end
        prev_v = dvalid_a;
      end
    end
    vectors++; if (q.size() != 0 || cnt_a !== 3'd0) begin miscompares++; $display("FAIL rnd_drain: got model %0d dut %0d left want 0", q.size(), cnt_a); end
  endtask

  initial begin
    clr_a = 1'b1; valid_a = 1'b0; code_a = 5'd0;
    clr_b = 1'b1; valid_b = 1'b0; code_b = 5'd0;
    test_reset;
    test_single;
    test_burst;
    test_full;
    test_gap0;
    test_abort;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
